// File: rtl/gf_inv_iter.sv
// Iterative GF(2^WIDTH) inverter: y = a^(2^WIDTH-2) by square-and-multiply, one operand at a time.
// Optional self-check of a*y == 1 on completion is enabled by defining GF_INV_CHECK_EN.
module gf_inv_iter #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH:0]  POLY  = 9'h11B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             chk_err,
  output logic             busy
);

  localparam int PW = 2 * WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("gf_inv_iter: WIDTH must lie in 2..16");
  end
  if (POLY[WIDTH] != 1'b1) begin : g_bad_poly
    $error("gf_inv_iter: POLY must have bit WIDTH set");
  end

  // Carry-less product folded by POLY from the top bit down.
  function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [PW-1:0] prod;
    logic [PW-1:0] poly_ext;
    prod     = '0;
    poly_ext = PW'(POLY);
    for (int i = 0; i < WIDTH; i++) begin
      if (y[i]) prod = prod ^ (PW'(x) << i);
    end
    for (int k = PW - 1; k >= WIDTH; k--) begin
      if (prod[k]) prod = prod ^ (poly_ext << (k - WIDTH));
    end
    return prod[WIDTH-1:0];
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] s_sq;
  logic [WIDTH-1:0] r_mul;
  logic             calc_done;

  assign s_sq      = gf_mul(s_q, s_q);
  assign r_mul     = gf_mul(r_q, s_sq);
  assign calc_done = (state_q == ST_CALC) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          s_d     = in_data;
          r_d     = WIDTH'(1);
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        s_d   = s_sq;
        r_d   = r_mul;
        cnt_d = cnt_q + CW'(1);
        if (calc_done) begin
          out_valid_d = 1'b1;
          out_data_d  = r_mul;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // Retiring cycle returns to IDLE; the next accept is one edge later.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

`ifdef GF_INV_CHECK_EN
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] chk_p;
  logic             chk_err_q, chk_err_d;

  assign chk_p = gf_mul(a_q, r_mul);

  always_comb begin
    a_d       = a_q;
    chk_err_d = chk_err_q;
    if (state_q == ST_IDLE && in_valid) a_d = in_data;
    if (calc_done) begin
      chk_err_d = (a_q != '0) && (chk_p != WIDTH'(1));
    end else if (state_q == ST_DONE && out_ready) begin
      chk_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      chk_err_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_gf_inv_iter.sv
// Directed bench for gf_inv_iter: GF(2^8)/0x11B and GF(2^4)/0x13 instances.
module tb_gf_inv_iter;

  typedef struct {
    logic [7:0] a;
    logic [7:0] y;
  } vec8_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] y;
  } vec4_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, chk_err8, busy8;
  logic [7:0] in_data8, out_data8;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, chk_err4, busy4;
  logic [3:0] in_data4, out_data4;

  int total = 0;
  int bad   = 0;

  gf_inv_iter #(.WIDTH(8), .POLY(9'h11B)) d8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .chk_err(chk_err8), .busy(busy8)
  );

  gf_inv_iter #(.WIDTH(4), .POLY(5'h13)) d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .chk_err(chk_err4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Shift-and-xtime model of GF(16) multiply with x^4 = x + 1.
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    logic       c;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      c  = aa[3];
      aa = {aa[2:0], 1'b0};
      if (c) aa = aa ^ 4'h3;
    end
    return p;
  endfunction

  task automatic xfer8(input logic [7:0] a, output logic [7:0] y, output int lat, output logic ce);
    int n;
    in_valid8 = 1'b1;
    in_data8  = a;
    n = 0;
    while (!in_ready8 && n < 40) begin @(posedge clk); #1; n++; end
    check("accept8", 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    in_data8  = ~a;
    lat = 0;
    while (!out_valid8 && lat < 40) begin @(posedge clk); #1; lat++; end
    y  = out_data8;
    ce = chk_err8;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("retire8", 32'(out_valid8), 32'd0);
  endtask

  task automatic xfer4(input logic [3:0] a, output logic [3:0] y, output int lat, output logic ce);
    int n;
    in_valid4 = 1'b1;
    in_data4  = a;
    n = 0;
    while (!in_ready4 && n < 40) begin @(posedge clk); #1; n++; end
    check("accept4", 32'(in_ready4), 32'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    in_data4  = ~a;
    lat = 0;
    while (!out_valid4 && lat < 40) begin @(posedge clk); #1; lat++; end
    y  = out_data4;
    ce = chk_err4;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("retire4", 32'(out_valid4), 32'd0);
  endtask

  initial begin
    vec8_t      v8[7];
    vec4_t      v4[2];
    logic [7:0] y8;
    logic [3:0] y4;
    int         lat;
    int         n;
    logic       ce;

    v8[0] = '{8'h53, 8'hCA};
    v8[1] = '{8'h00, 8'h00};
    v8[2] = '{8'h01, 8'h01};
    v8[3] = '{8'h02, 8'h8D};
    v8[4] = '{8'h03, 8'hF6};
    v8[5] = '{8'h8D, 8'h02};
    v8[6] = '{8'hCA, 8'h53};
    v4[0] = '{4'h2, 4'h9};
    v4[1] = '{4'hF, 4'h8};

    rst_n = 1'b0;
    in_valid8 = 1'b0; in_data8 = 8'h00; out_ready8 = 1'b0;
    in_valid4 = 1'b0; in_data4 = 4'h0; out_ready4 = 1'b0;
    #12;
    check("rst in_ready",  32'(in_ready8),  32'd1);
    check("rst out_valid", 32'(out_valid8), 32'd0);
    check("rst out_data",  32'(out_data8),  32'd0);
    check("rst chk_err",   32'(chk_err8),   32'd0);
    check("rst busy",      32'(busy8),      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      xfer8(v8[i].a, y8, lat, ce);
      check($sformatf("inv8[%0h]", v8[i].a), 32'(y8), 32'(v8[i].y));
      check($sformatf("lat8[%0h]", v8[i].a), 32'(lat), 32'd7);
      check($sformatf("chk8[%0h]", v8[i].a), 32'(ce), 32'd0);
    end

    for (int i = 0; i < 2; i++) begin
      xfer4(v4[i].a, y4, lat, ce);
      check($sformatf("inv4[%0h]", v4[i].a), 32'(y4), 32'(v4[i].y));
      check($sformatf("lat4[%0h]", v4[i].a), 32'(lat), 32'd3);
    end

    for (int a = 0; a < 16; a++) begin
      xfer4(4'(a), y4, lat, ce);
      if (a == 0) check("sweep4 zero", 32'(y4), 32'd0);
      else        check($sformatf("sweep4 a*y[%0h]", a), 32'(gf4_mul(4'(a), y4)), 32'd1);
      check($sformatf("sweep4 lat[%0h]", a), 32'(lat), 32'd3);
      check($sformatf("sweep4 chk[%0h]", a), 32'(ce), 32'd0);
    end

    // out_ready while idle must not disturb anything
    out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle out_ready valid", 32'(out_valid8), 32'd0);
    check("idle out_ready busy",  32'(busy8),      32'd0);
    out_ready8 = 1'b0;

    // backpressure: result held, second operand waits
    in_valid8 = 1'b1;
    in_data8  = 8'h53;
    @(posedge clk); #1;
    in_data8 = 8'h02;
    n = 0;
    while (!out_valid8 && n < 40) begin @(posedge clk); #1; n++; end
    check("bp lat", 32'(n), 32'd7);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp data c%0d", c),  32'(out_data8),  32'hCA);
      check($sformatf("bp ready c%0d", c), 32'(in_ready8),  32'd0);
      check($sformatf("bp valid c%0d", c), 32'(out_valid8), 32'd1);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("bp retire valid", 32'(out_valid8), 32'd0);
    check("bp retire ready", 32'(in_ready8),  32'd1);
    check("bp retire data",  32'(out_data8),  32'hCA);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("bp 2nd accept ready", 32'(in_ready8), 32'd0);
    check("bp 2nd accept busy",  32'(busy8),     32'd1);
    n = 0;
    while (!out_valid8 && n < 40) begin @(posedge clk); #1; n++; end
    check("bp 2nd lat",  32'(n),         32'd7);
    check("bp 2nd data", 32'(out_data8), 32'h8D);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;

    // asynchronous reset in the middle of an inversion
    in_valid8 = 1'b1;
    in_data8  = 8'h53;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst in_ready",  32'(in_ready8),  32'd1);
    check("midrst out_valid", 32'(out_valid8), 32'd0);
    check("midrst out_data",  32'(out_data8),  32'd0);
    check("midrst busy",      32'(busy8),      32'd0);
    check("midrst chk_err",   32'(chk_err8),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid8) n++;
    end
    check("midrst no stray valid", 32'(n), 32'd0);
    xfer8(8'h53, y8, lat, ce);
    check("postrst inv", 32'(y8),  32'hCA);
    check("postrst lat", 32'(lat), 32'd7);

`ifdef GF_INV_CHECK_EN
    in_valid8 = 1'b1;
    in_data8  = 8'h53;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    force d8.r_q = 8'h00;
    @(posedge clk); #1;
    release d8.r_q;
    n = 0;
    while (!out_valid8 && n < 40) begin @(posedge clk); #1; n++; end
    check("corrupt valid",   32'(out_valid8), 32'd1);
    check("corrupt chk_err", 32'(chk_err8),   32'd1);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("corrupt chk clear", 32'(chk_err8), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
